// File: rtl/imem_rom_arbiter.sv
// Two-port arbiter in front of the single-ported instruction ROM.
// F (fetch) and D (data constant loads) compete for one synchronous read
// port. Grants are combinational. Responses come back RD_LAT cycles later,
// tagged with the owning port and an error flag.
module imem_rom_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              rom_cen,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_q
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int LAST  = RD_LAT - 1;

  logic [CNT_W-1:0]  starve_cnt_reg;
  logic [ADDR_W-1:0] rom_addr_reg;

  // Response tag pipeline; owner bit is 1 for D, 0 for F.
  logic [RD_LAT-1:0] tag_valid_reg;
  logic [RD_LAT-1:0] tag_owner_reg;
  logic [RD_LAT-1:0] tag_err_reg;

  logic        f_win;
  logic        d_win;
  logic        any_gnt;
  logic [31:0] win_addr;
  logic        win_err;
  logic        rom_hit;
  logic        starved;

  // Arbitration: D has priority unless F has lost STARVE_MAX times in a row.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    starved  = (starve_cnt_reg == CNT_W'(STARVE_MAX));
    f_win    = !rst && f_req && (!d_req || starved);
    d_win    = !rst && d_req && !f_win;
    any_gnt  = f_win || d_win;
    win_addr = f_win ? f_addr : d_addr;
    win_err  = (win_addr[1:0] != 2'b00) || (win_addr[31:ADDR_W+2] != '0);
    rom_hit  = any_gnt && !win_err;
  end

  // ROM drive: enable only for legal grants, otherwise keep the last address.
  always_comb begin
    f_gnt    = f_win;
    d_gnt    = d_win;
    rom_cen  = !rom_hit;
    rom_addr = rom_hit ? win_addr[ADDR_W+1:2] : rom_addr_reg;
  end

  // Remember the last legal ROM address so it stays stable while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_reg <= '0;
    end else if (rom_hit) begin
      rom_addr_reg <= win_addr[ADDR_W+1:2];
    end
  end

  // Count consecutive cycles F asks but loses; a withdrawn request clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (f_req && !f_win) begin
      if (!starved) begin
        starve_cnt_reg <= starve_cnt_reg + 1'b1;
      end
    end else begin
      starve_cnt_reg <= '0;
    end
  end

  // Shift the grant tag through RD_LAT stages to line up with rom_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_owner_reg <= '0;
      tag_err_reg   <= '0;
    end else begin
      for (int i = LAST; i > 0; i--) begin
        tag_valid_reg[i] <= tag_valid_reg[i-1];
        tag_owner_reg[i] <= tag_owner_reg[i-1];
        tag_err_reg[i]   <= tag_err_reg[i-1];
      end
      tag_valid_reg[0] <= any_gnt;
      tag_owner_reg[0] <= d_win;
      tag_err_reg[0]   <= any_gnt && win_err;
    end
  end

  // Steer the final stage to its owner; data is zero unless a good response.
  always_comb begin
    f_rvalid = tag_valid_reg[LAST] && !tag_owner_reg[LAST];
    d_rvalid = tag_valid_reg[LAST] &&  tag_owner_reg[LAST];
    f_err    = f_rvalid && tag_err_reg[LAST];
    d_err    = d_rvalid && tag_err_reg[LAST];
    f_rdata  = (f_rvalid && !tag_err_reg[LAST]) ? rom_q : 32'h0;
    d_rdata  = (d_rvalid && !tag_err_reg[LAST]) ? rom_q : 32'h0;
  end

endmodule
